// File: rtl/conf_bus_pkg.sv
// Shared types and defaults for the configuration-bus initiator: FSM state
// encoding, default widths/timeout and small sizing helpers.
package conf_bus_pkg;

   typedef enum logic [1:0] {
      ST_ADDR  = 2'd0,
      ST_DATA  = 2'd1,
      ST_WRITE = 2'd2
   } conf_state_e;

   localparam int unsigned DEF_ADDR_WIDTH     = 16;
   localparam int unsigned DEF_DATA_WIDTH     = 16;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 255;
   localparam int unsigned DEF_ADDR_BYTES     = DEF_ADDR_WIDTH / 8;
   localparam int unsigned DEF_DATA_BYTES     = DEF_DATA_WIDTH / 8;

   function automatic int unsigned bytes_of(input int unsigned width);
      return width / 8;
   endfunction

   // Bits needed to hold the values 0 .. n-1 (at least one bit).
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/conf_timeout_counter.sv
// Write-phase cycle counter: counts while enabled, saturates at the last
// cycle and flags it with a combinational terminal-count pulse.
module conf_timeout_counter
   import conf_bus_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   input  logic clr_i,
   output logic tc_o
);

   localparam int unsigned     CNT_W = cnt_width(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != LAST)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/conf_bus_master.sv
// Configuration-bus initiator: bytes in, one register write per frame out.
// Optional no-acknowledge abort is built when CONF_BUS_TIMEOUT_EN is defined.
module conf_bus_master
   import conf_bus_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            rx_data,
   input  logic                  rx_rdy,
   output logic                  rx_ack,
   output logic [ADDR_WIDTH-1:0] si_addr,
   output logic [DATA_WIDTH-1:0] si_data,
   output logic                  si_rdy,
   input  logic                  si_ack,
   output logic                  err_noack,
   output conf_state_e           dbg_state
);

   localparam int unsigned ADDR_BYTES = bytes_of(ADDR_WIDTH);
   localparam int unsigned DATA_BYTES = bytes_of(DATA_WIDTH);
   localparam int unsigned MAX_BYTES  = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
   localparam int unsigned BCNT_W     = cnt_width(MAX_BYTES);
   localparam logic [BCNT_W-1:0] ADDR_LAST = BCNT_W'(ADDR_BYTES - 1);
   localparam logic [BCNT_W-1:0] DATA_LAST = BCNT_W'(DATA_BYTES - 1);

   conf_state_e           state_q;
   logic [BCNT_W-1:0]     byte_cnt_q;
   logic [ADDR_WIDTH-1:0] addr_sh_q;
   logic [ADDR_WIDTH-1:0] addr_sh_d;
   logic [DATA_WIDTH-1:0] data_sh_q;
   logic [DATA_WIDTH-1:0] data_sh_d;
   logic [ADDR_WIDTH-1:0] si_addr_q;
   logic [DATA_WIDTH-1:0] si_data_q;
   logic                  si_rdy_q;
   logic                  err_noack_q;
   logic                  timeout_tc;

   // Handshakes: a byte moves when rx_rdy && rx_ack on a rising edge; the
   // source must hold it otherwise. A register write completes on the edge
   // where si_rdy && si_ack; si_addr/si_data are frozen until then.
   assign rx_ack = rx_rdy && (state_q != ST_WRITE);

   // Shift registers collect the frame so the bus outputs keep the previous
   // write's values until the new frame is complete.
   assign addr_sh_d = (addr_sh_q << 8) | ADDR_WIDTH'(rx_data);
   assign data_sh_d = (data_sh_q << 8) | DATA_WIDTH'(rx_data);

`ifdef CONF_BUS_TIMEOUT_EN
   conf_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_i (clk),
      .rst_ni(rst),
      .en_i  (state_q == ST_WRITE),
      .clr_i (state_q != ST_WRITE),
      .tc_o  (timeout_tc)
   );
`else
   assign timeout_tc = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_ADDR;
         byte_cnt_q  <= '0;
         addr_sh_q   <= '0;
         data_sh_q   <= '0;
         si_addr_q   <= '0;
         si_data_q   <= '0;
         si_rdy_q    <= 1'b0;
         err_noack_q <= 1'b0;
      end else begin
         err_noack_q <= 1'b0;
         case (state_q)
            ST_ADDR: begin
               if (rx_rdy) begin
                  addr_sh_q <= addr_sh_d;
                  if (byte_cnt_q == ADDR_LAST) begin
                     byte_cnt_q <= '0;
                     state_q    <= ST_DATA;
                  end else begin
                     byte_cnt_q <= byte_cnt_q + 1'b1;
                  end
               end
            end
            ST_DATA: begin
               if (rx_rdy) begin
                  data_sh_q <= data_sh_d;
                  if (byte_cnt_q == DATA_LAST) begin
                     byte_cnt_q <= '0;
                     si_addr_q  <= addr_sh_q;
                     si_data_q  <= data_sh_d;
                     si_rdy_q   <= 1'b1;
                     state_q    <= ST_WRITE;
                  end else begin
                     byte_cnt_q <= byte_cnt_q + 1'b1;
                  end
               end
            end
            ST_WRITE: begin
               // An acknowledge on the terminal cycle still counts as success.
               if (si_ack) begin
                  si_rdy_q <= 1'b0;
                  state_q  <= ST_ADDR;
               end else if (timeout_tc) begin
                  si_rdy_q    <= 1'b0;
                  err_noack_q <= 1'b1;
                  state_q     <= ST_ADDR;
               end
            end
            default: begin
               state_q  <= ST_ADDR;
               si_rdy_q <= 1'b0;
            end
         endcase
      end
   end

   assign si_addr   = si_addr_q;
   assign si_data   = si_data_q;
   assign si_rdy    = si_rdy_q;
   assign err_noack = err_noack_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_conf_bus_master.sv
// Bench for conf_bus_master: byte driver, register-bank responder, write
// scoreboard and per-cycle protocol checks; covers both timeout builds.
module tb_conf_bus_master;
   import conf_bus_pkg::*;

   localparam int AW = 16;
   localparam int DW = 16;
   localparam int TO = 8;
   localparam logic [AW-1:0] REG_A = 16'h000A;
   localparam logic [AW-1:0] REG_B = 16'h000B;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [7:0]    rx_data = 8'h00;
   logic          rx_rdy = 1'b0;
   logic          rx_ack;
   logic [AW-1:0] si_addr;
   logic [DW-1:0] si_data;
   logic          si_rdy;
   logic          si_ack;
   logic          err_noack;
   conf_state_e   dbg_state;

   int errors = 0;
   int checks = 0;
   logic [AW+DW-1:0] exp_q[$];

   int cyc = 0;
   int ack_delay = 0;
   int rdy_cnt = 0;
   logic [DW-1:0] reg_a = '0;
   logic [DW-1:0] reg_b = '0;

   int cur_len = 0;
   int last_rdy_len = 0;
   int rdy_falls = 0;
   int err_cnt = 0;
   int last_ack_cyc = 0;
   int last_acc_cyc = 0;
   int frame_first_cyc = 0;
   logic          prev_rdy = 1'b0;
   logic [AW-1:0] prev_addr = '0;
   logic [DW-1:0] prev_data = '0;

   conf_bus_master #(
      .ADDR_WIDTH    (AW),
      .DATA_WIDTH    (DW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx_data  (rx_data),
      .rx_rdy   (rx_rdy),
      .rx_ack   (rx_ack),
      .si_addr  (si_addr),
      .si_data  (si_data),
      .si_rdy   (si_rdy),
      .si_ack   (si_ack),
      .err_noack(err_noack),
      .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

   // ---------------- register bank responder ----------------
   assign si_ack = si_rdy && ((si_addr == REG_A) || (si_addr == REG_B)) && (rdy_cnt >= ack_delay);

   always @(posedge clk) begin
      if (si_rdy && si_ack) begin
         if (si_addr == REG_A) reg_a <= si_data;
         else                  reg_b <= si_data;
      end
      if (!si_rdy) rdy_cnt <= 0;
      else         rdy_cnt <= rdy_cnt + 1;
   end

   // ---------------- monitor + scoreboard ----------------
   always @(negedge clk) begin
      logic [AW+DW-1:0] exp;
      if (!rst) begin
         cur_len  = 0;
         prev_rdy = 1'b0;
      end else begin
         checks++;
         if (rx_ack !== (rx_rdy && !si_rdy)) begin
            errors++;
            $display("FAIL rx_ack cycle %0d: got %b, want %b", cyc, rx_ack, rx_rdy && !si_rdy);
         end
         if (prev_rdy && si_rdy) begin
            checks++;
            if (si_addr !== prev_addr || si_data !== prev_data) begin
               errors++;
               $display("FAIL stable cycle %0d: addr/data %h/%h, want %h/%h", cyc, si_addr, si_data, prev_addr, prev_data);
            end
         end
         if (err_noack !== 1'b0) begin
            err_cnt++;
            checks++;
`ifdef CONF_BUS_TIMEOUT_EN
            if (si_rdy || !prev_rdy) begin
               errors++;
               $display("FAIL err_timing cycle %0d: si_rdy=%b prev_rdy=%b, want 0/1", cyc, si_rdy, prev_rdy);
            end
`else
            errors++;
            $display("FAIL err_noack cycle %0d: got %b, want 0", cyc, err_noack);
`endif
         end
         if (si_rdy && si_ack) begin
            last_ack_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL write_unexpected cycle %0d: got %h/%h, want none", cyc, si_addr, si_data);
            end else begin
               exp = exp_q.pop_front();
               if ({si_addr, si_data} !== exp) begin
                  errors++;
                  $display("FAIL write cycle %0d: got %h, want %h", cyc, {si_addr, si_data}, exp);
               end
            end
         end
         if (si_rdy) begin
            cur_len++;
         end else if (cur_len > 0) begin
            last_rdy_len = cur_len;
            cur_len = 0;
            rdy_falls++;
         end
         prev_rdy  = si_rdy;
         prev_addr = si_addr;
         prev_data = si_data;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit acked;
      int n;
      rx_data = b;
      rx_rdy  = 1'b1;
      acked = 0;
      n = 0;
      while (!acked && n < 2000) begin
         @(negedge clk);
         acked = rx_ack;
         if (acked) last_acc_cyc = cyc;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acked) begin
         checks++;
         errors++;
         $display("FAIL send_byte: byte %h not accepted, want accept within 2000 cycles", b);
      end
   endtask

   task automatic send_frame(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit push);
      if (push) exp_q.push_back({a, d});
      send_byte(a[15:8]);
      frame_first_cyc = last_acc_cyc;
      send_byte(a[7:0]);
      send_byte(d[15:8]);
      send_byte(d[7:0]);
   endtask

   task automatic idle();
      rx_rdy = 1'b0;
   endtask

   task automatic wait_falls(input int target);
      int n;
      n = 0;
      while (rdy_falls < target && n < 500) begin
         tick();
         n++;
      end
      if (rdy_falls < target) begin
         checks++;
         errors++;
         $display("FAIL wait_write: si_rdy falls %0d, want %0d", rdy_falls, target);
      end
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b0;
      rx_rdy = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      checks++;
      if (si_addr !== '0 || si_data !== '0) begin
         errors++;
         $display("FAIL reset_bus: addr/data %h/%h, want 0/0", si_addr, si_data);
      end
      checks++;
      if (si_rdy !== 1'b0 || err_noack !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctl: si_rdy=%b err_noack=%b, want 0/0", si_rdy, err_noack);
      end
      checks++;
      if (dbg_state !== ST_ADDR) begin
         errors++;
         $display("FAIL reset_state: got %0d, want %0d", dbg_state, ST_ADDR);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      tick();
   endtask

   task automatic test_single();
      int f0;
      ack_delay = 0;
      f0 = rdy_falls;
      send_frame(REG_A, 16'h1234, 1);
      idle();
      wait_falls(f0 + 1);
      checks++;
      if (last_rdy_len !== 1) begin
         errors++;
         $display("FAIL single_len: si_rdy high %0d cycles, want 1", last_rdy_len);
      end
      checks++;
      if (last_ack_cyc !== last_acc_cyc + 1) begin
         errors++;
         $display("FAIL single_latency: write cycle %0d, want %0d", last_ack_cyc, last_acc_cyc + 1);
      end
      checks++;
      if (reg_a !== 16'h1234) begin
         errors++;
         $display("FAIL single_reg: reg_a %h, want 1234", reg_a);
      end
   endtask

   task automatic test_back_to_back();
      int f0;
      int c0;
      ack_delay = 0;
      f0 = rdy_falls;
      send_frame(REG_A, 16'h1111, 1);
      c0 = frame_first_cyc;
      send_frame(REG_B, 16'h2222, 1);
      idle();
      wait_falls(f0 + 2);
      checks++;
      if (last_ack_cyc - c0 + 1 !== 10) begin
         errors++;
         $display("FAIL b2b_cycles: took %0d cycles, want 10", last_ack_cyc - c0 + 1);
      end
      checks++;
      if (reg_a !== 16'h1111 || reg_b !== 16'h2222) begin
         errors++;
         $display("FAIL b2b_regs: reg_a/reg_b %h/%h, want 1111/2222", reg_a, reg_b);
      end
   endtask

   task automatic test_ack_delay();
      int f0;
      int c0;
      ack_delay = 3;
      f0 = rdy_falls;
      send_frame(REG_A, 16'h5678, 1);
      c0 = frame_first_cyc;
      send_frame(REG_B, 16'h9ABC, 1);
      idle();
      wait_falls(f0 + 2);
      checks++;
      if (last_rdy_len !== 4) begin
         errors++;
         $display("FAIL delay_len: si_rdy high %0d cycles, want 4", last_rdy_len);
      end
      checks++;
      if (last_ack_cyc - c0 + 1 !== 16) begin
         errors++;
         $display("FAIL delay_cycles: took %0d cycles, want 16", last_ack_cyc - c0 + 1);
      end
      checks++;
      if (reg_a !== 16'h5678 || reg_b !== 16'h9ABC) begin
         errors++;
         $display("FAIL delay_regs: reg_a/reg_b %h/%h, want 5678/9abc", reg_a, reg_b);
      end
      ack_delay = 0;
   endtask

   task automatic test_reset_mid_frame();
      int f0;
      send_byte(8'h00);
      send_byte(8'h0A);
      send_byte(8'hBE);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (si_addr !== '0 || si_data !== '0 || si_rdy !== 1'b0) begin
         errors++;
         $display("FAIL midframe_reset: addr/data/rdy %h/%h/%b, want 0/0/0", si_addr, si_data, si_rdy);
      end
      checks++;
      if (dbg_state !== ST_ADDR) begin
         errors++;
         $display("FAIL midframe_state: got %0d, want %0d", dbg_state, ST_ADDR);
      end
      idle();
      @(posedge clk);
      #1;
      rst = 1'b1;
      tick();
      f0 = rdy_falls;
      send_frame(REG_A, 16'hBEEF, 1);
      idle();
      wait_falls(f0 + 1);
      checks++;
      if (reg_a !== 16'hBEEF) begin
         errors++;
         $display("FAIL midframe_reg: reg_a %h, want beef", reg_a);
      end
   endtask

   task automatic test_reset_mid_write();
      send_frame(16'h00FF, 16'h0F0F, 0);
      idle();
      repeat (3) tick();
      checks++;
      if (si_rdy !== 1'b1) begin
         errors++;
         $display("FAIL midwrite_pending: si_rdy %b, want 1", si_rdy);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (si_rdy !== 1'b0 || si_addr !== '0 || err_noack !== 1'b0) begin
         errors++;
         $display("FAIL midwrite_reset: rdy/addr/err %b/%h/%b, want 0/0/0", si_rdy, si_addr, err_noack);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      tick();
   endtask

`ifdef CONF_BUS_TIMEOUT_EN
   task automatic test_timeout();
      int f0;
      int e0;
      f0 = rdy_falls;
      e0 = err_cnt;
      send_frame(16'h00FF, 16'hDEAD, 0);
      idle();
      wait_falls(f0 + 1);
      repeat (3) tick();
      checks++;
      if (last_rdy_len !== TO) begin
         errors++;
         $display("FAIL timeout_len: si_rdy high %0d cycles, want %0d", last_rdy_len, TO);
      end
      checks++;
      if (err_cnt - e0 !== 1) begin
         errors++;
         $display("FAIL timeout_err: err_noack pulses %0d, want 1", err_cnt - e0);
      end
      ack_delay = TO - 1;
      e0 = err_cnt;
      send_frame(REG_A, 16'h7E57, 1);
      idle();
      wait_falls(f0 + 2);
      repeat (2) tick();
      checks++;
      if (last_rdy_len !== TO || err_cnt !== e0 || reg_a !== 16'h7E57) begin
         errors++;
         $display("FAIL timeout_lastack: len/err/reg %0d/%0d/%h, want %0d/0/7e57", last_rdy_len, err_cnt - e0, reg_a, TO);
      end
      ack_delay = 0;
      send_frame(REG_B, 16'h4321, 1);
      idle();
      wait_falls(f0 + 3);
      checks++;
      if (reg_b !== 16'h4321) begin
         errors++;
         $display("FAIL timeout_next: reg_b %h, want 4321", reg_b);
      end
   endtask
`else
   task automatic test_no_timeout();
      int held;
      int e0;
      e0 = err_cnt;
      send_frame(16'h00FF, 16'hDEAD, 0);
      idle();
      held = 0;
      repeat (1000) begin
         @(negedge clk);
         if (si_rdy === 1'b1 && err_noack === 1'b0) held++;
      end
      checks++;
      if (held !== 1000 || err_cnt !== e0) begin
         errors++;
         $display("FAIL no_timeout: si_rdy held %0d cycles, errs %0d, want 1000/0", held, err_cnt - e0);
      end
      @(posedge clk);
      #1;
      do_reset();
   endtask
`endif

   task automatic test_random();
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [DW-1:0] ea;
      logic [DW-1:0] eb;
      int f0;
      ea = reg_a;
      eb = reg_b;
      for (int i = 0; i < 8; i++) begin
         ack_delay = $urandom_range(0, 2);
         a = ($urandom_range(0, 1) == 0) ? REG_A : REG_B;
         d = DW'($urandom);
         repeat ($urandom_range(0, 3)) tick();
         f0 = rdy_falls;
         send_frame(a, d, 1);
         idle();
         wait_falls(f0 + 1);
         if (a == REG_A) ea = d;
         else            eb = d;
      end
      checks++;
      if (reg_a !== ea || reg_b !== eb) begin
         errors++;
         $display("FAIL random_regs: reg_a/reg_b %h/%h, want %h/%h", reg_a, reg_b, ea, eb);
      end
      ack_delay = 0;
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_ack_delay();
      test_reset_mid_frame();
      test_reset_mid_write();
`ifdef CONF_BUS_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      test_random();
      repeat (4) tick();
      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d writes outstanding, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
